excp_trap_ctrl: RTL and testbench
=================================

EXCP_TRAP_CTRL -- requirements
Module: excp_trap_ctrl

Interface
REQ-001 Parameter: none; widths come from `XLEN and `PC_SIZE in mcu_defines.v.
REQ-002 clk  in  1  single core clock; all state on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 dbg_mode  in  1  core in debug mode.
REQ-005 excp_req / excp_cause  in  1 / XLEN  synchronous exception request, held until excp_ack.
REQ-006 irq_req / irq_cause  in  1 / XLEN  interrupt request (level) with cause.
REQ-007 irq_glb_en  in  1  mstatus.MIE.
REQ-008 mret_req  in  1  mret commit request, held until mret_ack.
REQ-009 epc_in  in  PC_SIZE  PC of the trapping or next instruction.
REQ-010 mtvec / mepc  in  PC_SIZE  CSR values.
REQ-011 oitf_empty  in  1  no outstanding long-pipe instructions.
REQ-012 flush_ack  in  1  IFU accepted the flush.
REQ-013 flush_req / flush_pc  out  1 / PC_SIZE  pipeline flush and redirect target.
REQ-014 excp_ack / irq_ack / mret_ack  out  1 each  one-cycle accept pulses.
REQ-015 excp_taken_ena / irq_taken_ena / mret_ena  out  1 each  one-cycle commit strobes to the CSR commit logic.
REQ-016 trap_cause / trap_epc  out  XLEN / PC_SIZE  captured cause and EPC, valid while busy.
REQ-017 busy  out  1  state != IDLE.

Function
REQ-018 FSM states: IDLE, QUIESCE, FLUSH, COMMIT.
REQ-019 IDLE: accept one event per cycle in priority order: excp_req > mret_req > (irq_req & irq_glb_en & ~dbg_mode); go to QUIESCE.
REQ-020 On accept: capture the event type, the cause (0 for mret), epc_in and the target; the acks are not yet issued.
REQ-021 QUIESCE: remain until oitf_empty=1, then go to FLUSH on the next edge.
REQ-022 FLUSH: hold flush_req=1 and a stable flush_pc until flush_ack=1; on the ack edge go to COMMIT.
REQ-023 COMMIT: lasts exactly one cycle; pulse the matching *_ack and exactly one of excp_taken_ena/irq_taken_ena/mret_ena; return to IDLE.
REQ-024 Minimum latency: request at cycle N with oitf_empty and flush_ack both high gives QUIESCE at N+1, FLUSH at N+2 and the COMMIT strobe at N+3.
REQ-025 Target for excp and mret:
- excp: {mtvec[PC_SIZE-1:2],2'b00}.
- mret: mepc sampled at accept.
REQ-026 Target for irq:
- mtvec[1:0]==2'b01: base + (irq_cause[4:0]<<2), modulo 2^PC_SIZE, wrap allowed.
- otherwise: the excp target.
REQ-027 An irq deasserted after accept is still committed; no abort path exists.
REQ-028 Requests arriving while busy are ignored (not queued); held requests are re-arbitrated in the IDLE cycle after COMMIT.
REQ-029 A simultaneous excp and irq commits the excp only; the irq stays pending at its source.
REQ-030 In dbg_mode, excp and mret proceed normally and irq is never accepted.

Reset
REQ-031 While rst=1, state=IDLE and every output and capture register is 0, regardless of the current state.
REQ-032 On reset mid-operation, no ack or strobe is ever emitted for the interrupted event.

Configuration
REQ-033 Macro MCU_TRAP_NMI_EN adds input nmi_req (1-bit, level) with priority above excp.
- nmi target: mtvec base, non-vectored.
- nmi cause: `XLEN'h1 with the MSB set.
- nmi commits through irq_taken_ena; it is not masked by irq_glb_en, but is masked by dbg_mode.
- Acked via irq_ack.
REQ-034 Without MCU_TRAP_NMI_EN, the port and its logic are absent and behaviour is REQ-019 unchanged.

Structure
REQ-035 State encodings (2-bit), the event-type encoding and the NMI cause constant are defined in mcu_defines.v.
REQ-036 The target computation lives in one combinational sub-module, excp_trap_vec.

Verification
REQ-037 excp_req=1, cause=2, mtvec=0x100, oitf_empty=1, flush_ack=1 at N -> flush_pc=0x100 at N+2; excp_taken_ena and excp_ack pulse at N+3; trap_cause=2.
REQ-038 irq_req=1, cause=7, mtvec=0x201, MIE=1 -> flush_pc=0x21C; irq_taken_ena pulses once.
REQ-039 excp_req and irq_req in the same cycle -> excp commits first; the irq commits in a second sequence starting the cycle after.
REQ-040 oitf_empty=0 for 5 cycles, then flush_ack delayed 3 cycles -> flush_req stays high with a stable pc for exactly 3 cycles; one strobe.
REQ-041 rst asserted during FLUSH -> all outputs 0 immediately; no ack/strobe until a new request.
REQ-042 dbg_mode=1 with irq pending, MIE=1 -> no accept; mret_req with mepc=0x80 -> flush_pc=0x80 and mret_ena pulses.

Source files
------------

// File: rtl/excp_trap_ctrl_pkg.sv
// Shared types and constants for the exception/trap controller.
// XLEN and PC_SIZE normally come from mcu_defines.v; the defaults below are
// used only when those macros are not already defined.
// Optional feature macro: MCU_TRAP_NMI_EN (adds a non-maskable interrupt input).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

package excp_trap_ctrl_pkg;

    localparam int XLEN    = `XLEN;
    localparam int PC_SIZE = `PC_SIZE;

    // Controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUIESCE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_COMMIT  = 2'd3
    } trap_state_e;

    // Kind of event currently owned by the controller.
    typedef enum logic [1:0] {
        EVT_EXCP = 2'd0,
        EVT_IRQ  = 2'd1,
        EVT_MRET = 2'd2,
        EVT_NMI  = 2'd3
    } trap_evt_e;

    // NMI cause: interrupt flag (MSB) together with code 1.
    localparam logic [XLEN-1:0] NMI_CAUSE = {1'b1, {(XLEN-2){1'b0}}, 1'b1};

endpackage

// File: rtl/excp_trap_vec.sv
// Redirect target computation for a trap event (purely combinational).
// Exceptions and NMIs use the aligned mtvec base, mret uses mepc, and
// interrupts are vectored off the base when mtvec mode is 2'b01.
module excp_trap_vec
    import excp_trap_ctrl_pkg::*;
(
    input  trap_evt_e            evt_i,
    input  logic [PC_SIZE-1:0]   mtvec_i,
    input  logic [PC_SIZE-1:0]   mepc_i,
    input  logic [4:0]           irq_cause_lo_i,
    output logic [PC_SIZE-1:0]   target_o
);

    logic [PC_SIZE-1:0] base;
    logic [PC_SIZE-1:0] vecOffset;

    assign base      = {mtvec_i[PC_SIZE-1:2], 2'b00};
    assign vecOffset = PC_SIZE'({irq_cause_lo_i, 2'b00});

    // Select the target by event kind; the vectored add wraps at PC_SIZE bits.
    always_comb begin
        target_o = base;
        case (evt_i)
            EVT_MRET: target_o = mepc_i;
            EVT_IRQ:  target_o = (mtvec_i[1:0] == 2'b01) ? (base + vecOffset) : base;
            default:  target_o = base;
        endcase
    end

endmodule

// File: rtl/excp_trap_ctrl.sv
// Exception / interrupt / mret trap controller.
// Accepts one event at a time, waits for the long pipe to drain, flushes the
// pipeline to the computed target and then commits with one-cycle strobes.
// Optional feature macro: MCU_TRAP_NMI_EN (adds nmi_req_i, highest priority).
module excp_trap_ctrl
    import excp_trap_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
`ifdef MCU_TRAP_NMI_EN
    input  logic                 nmi_req_i,
`endif
    input  logic                 dbg_mode_i,
    input  logic                 excp_req_i,
    input  logic [XLEN-1:0]      excp_cause_i,
    input  logic                 irq_req_i,
    input  logic [XLEN-1:0]      irq_cause_i,
    input  logic                 irq_glb_en_i,
    input  logic                 mret_req_i,
    input  logic [PC_SIZE-1:0]   epc_in_i,
    input  logic [PC_SIZE-1:0]   mtvec_i,
    input  logic [PC_SIZE-1:0]   mepc_i,
    input  logic                 oitf_empty_i,
    input  logic                 flush_ack_i,
    output logic                 flush_req_o,
    output logic [PC_SIZE-1:0]   flush_pc_o,
    output logic                 excp_ack_o,
    output logic                 irq_ack_o,
    output logic                 mret_ack_o,
    output logic                 excp_taken_ena_o,
    output logic                 irq_taken_ena_o,
    output logic                 mret_ena_o,
    output logic [XLEN-1:0]      trap_cause_o,
    output logic [PC_SIZE-1:0]   trap_epc_o,
    output logic                 busy_o
);

    trap_state_e          state_q;
    trap_evt_e            evt_q;
    trap_evt_e            evt_d;
    logic [XLEN-1:0]      cause_q;
    logic [XLEN-1:0]      cause_d;
    logic [PC_SIZE-1:0]   epc_q;
    logic [PC_SIZE-1:0]   target_q;
    logic [PC_SIZE-1:0]   target_d;
    logic                 accValid;
    logic                 nmiReq;
    logic                 flushReq_q;
    logic                 excpAck_q;
    logic                 irqAck_q;
    logic                 mretAck_q;
    logic                 excpTaken_q;
    logic                 irqTaken_q;
    logic                 mretEna_q;

`ifdef MCU_TRAP_NMI_EN
    assign nmiReq = nmi_req_i & ~dbg_mode_i;
`else
    assign nmiReq = 1'b0;
`endif

    // Fixed-priority arbitration of the requests seen while idle.
    always_comb begin
        accValid = 1'b0;
        evt_d    = EVT_EXCP;
        cause_d  = '0;
        if (nmiReq) begin
            accValid = 1'b1;
            evt_d    = EVT_NMI;
            cause_d  = NMI_CAUSE;
        end else if (excp_req_i) begin
            accValid = 1'b1;
            evt_d    = EVT_EXCP;
            cause_d  = excp_cause_i;
        end else if (mret_req_i) begin
            accValid = 1'b1;
            evt_d    = EVT_MRET;
            cause_d  = '0;
        end else if (irq_req_i && irq_glb_en_i && !dbg_mode_i) begin
            accValid = 1'b1;
            evt_d    = EVT_IRQ;
            cause_d  = irq_cause_i;
        end
    end

    excp_trap_vec u_vec (
        .evt_i          (evt_d),
        .mtvec_i        (mtvec_i),
        .mepc_i         (mepc_i),
        .irq_cause_lo_i (irq_cause_i[4:0]),
        .target_o       (target_d)
    );

    // Trap sequencing FSM; all outputs are registered and cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            evt_q       <= EVT_EXCP;
            cause_q     <= '0;
            epc_q       <= '0;
            target_q    <= '0;
            flushReq_q  <= 1'b0;
            excpAck_q   <= 1'b0;
            irqAck_q    <= 1'b0;
            mretAck_q   <= 1'b0;
            excpTaken_q <= 1'b0;
            irqTaken_q  <= 1'b0;
            mretEna_q   <= 1'b0;
        end else begin
            excpAck_q   <= 1'b0;
            irqAck_q    <= 1'b0;
            mretAck_q   <= 1'b0;
            excpTaken_q <= 1'b0;
            irqTaken_q  <= 1'b0;
            mretEna_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accValid) begin
                        state_q  <= ST_QUIESCE;
                        evt_q    <= evt_d;
                        cause_q  <= cause_d;
                        epc_q    <= epc_in_i;
                        target_q <= target_d;
                    end
                end
                ST_QUIESCE: begin
                    if (oitf_empty_i) begin
                        state_q    <= ST_FLUSH;
                        flushReq_q <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_ack_i) begin
                        state_q    <= ST_COMMIT;
                        flushReq_q <= 1'b0;
                        case (evt_q)
                            EVT_EXCP: begin
                                excpAck_q   <= 1'b1;
                                excpTaken_q <= 1'b1;
                            end
                            EVT_MRET: begin
                                mretAck_q <= 1'b1;
                                mretEna_q <= 1'b1;
                            end
                            default: begin
                                irqAck_q   <= 1'b1;
                                irqTaken_q <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign flush_req_o      = flushReq_q;
    assign flush_pc_o       = target_q;
    assign excp_ack_o       = excpAck_q;
    assign irq_ack_o        = irqAck_q;
    assign mret_ack_o       = mretAck_q;
    assign excp_taken_ena_o = excpTaken_q;
    assign irq_taken_ena_o  = irqTaken_q;
    assign mret_ena_o       = mretEna_q;
    assign trap_cause_o     = cause_q;
    assign trap_epc_o       = epc_q;
    assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_excp_trap_ctrl.sv
// Scoreboard testbench for excp_trap_ctrl.
// Stimulus pushes the hand-computed commit it expects; a negedge monitor pops
// and compares whenever the DUT raises a commit strobe or ack.
module tb_excp_trap_ctrl;
    import excp_trap_ctrl_pkg::*;

    typedef struct {
        logic [2:0]          kind;
        logic [XLEN-1:0]     cause;
        logic [PC_SIZE-1:0]  epc;
        logic [PC_SIZE-1:0]  target;
    } exp_t;

    localparam logic [2:0] K_EXCP = 3'b100;
    localparam logic [2:0] K_IRQ  = 3'b010;
    localparam logic [2:0] K_MRET = 3'b001;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
`ifdef MCU_TRAP_NMI_EN
    logic                nmiReq = 1'b0;
`endif
    logic                dbgMode = 1'b0;
    logic                excpReq = 1'b0;
    logic [XLEN-1:0]     excpCause = '0;
    logic                irqReq = 1'b0;
    logic [XLEN-1:0]     irqCause = '0;
    logic                irqGlbEn = 1'b0;
    logic                mretReq = 1'b0;
    logic [PC_SIZE-1:0]  epcIn = '0;
    logic [PC_SIZE-1:0]  mtvec = '0;
    logic [PC_SIZE-1:0]  mepc = '0;
    logic                oitfEmpty = 1'b1;
    logic                flushAck = 1'b1;
    logic                flushReq;
    logic [PC_SIZE-1:0]  flushPc;
    logic                excpAck, irqAck, mretAck;
    logic                excpTaken, irqTaken, mretEna;
    logic [XLEN-1:0]     trapCause;
    logic [PC_SIZE-1:0]  trapEpc;
    logic                busy;

    int   checks = 0;
    int   failures = 0;
    exp_t expQ[$];
    exp_t monEntry;

    excp_trap_ctrl dut (
        .clk              (clk),
        .rst              (rst),
`ifdef MCU_TRAP_NMI_EN
        .nmi_req_i        (nmiReq),
`endif
        .dbg_mode_i       (dbgMode),
        .excp_req_i       (excpReq),
        .excp_cause_i     (excpCause),
        .irq_req_i        (irqReq),
        .irq_cause_i      (irqCause),
        .irq_glb_en_i     (irqGlbEn),
        .mret_req_i       (mretReq),
        .epc_in_i         (epcIn),
        .mtvec_i          (mtvec),
        .mepc_i           (mepc),
        .oitf_empty_i     (oitfEmpty),
        .flush_ack_i      (flushAck),
        .flush_req_o      (flushReq),
        .flush_pc_o       (flushPc),
        .excp_ack_o       (excpAck),
        .irq_ack_o        (irqAck),
        .mret_ack_o       (mretAck),
        .excp_taken_ena_o (excpTaken),
        .irq_taken_ena_o  (irqTaken),
        .mret_ena_o       (mretEna),
        .trap_cause_o     (trapCause),
        .trap_epc_o       (trapEpc),
        .busy_o           (busy)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic excpR, input logic [XLEN-1:0] excpC,
                                 input logic mretR, input logic irqR,
                                 input logic [XLEN-1:0] irqC, input logic [PC_SIZE-1:0] epc);
        excpReq   = excpR;
        excpCause = excpC;
        mretReq   = mretR;
        irqReq    = irqR;
        irqCause  = irqC;
        epcIn     = epc;
    endtask

    task automatic pushExp(input logic [2:0] kind, input logic [XLEN-1:0] cause,
                           input logic [PC_SIZE-1:0] epc, input logic [PC_SIZE-1:0] target);
        exp_t e;
        e.kind   = kind;
        e.cause  = cause;
        e.epc    = epc;
        e.target = target;
        expQ.push_back(e);
    endtask

    // Wait (bounded) for the selected ack, then move to the next cycle.
    task automatic waitAck(input logic [2:0] kind, input string name);
        bit got = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ({excpAck, irqAck, mretAck} == kind) begin
                got = 1;
                break;
            end
        end
        checkOutput(name, {127'd0, got}, 128'd1);
        stepCycle();
    endtask

    task automatic checkAllZero(input string name);
        checkOutput(name, {busy, flushReq, flushPc, excpAck, irqAck, mretAck,
                           excpTaken, irqTaken, mretEna, trapCause, trapEpc}, 128'd0);
    endtask

    // Scoreboard monitor: compare flush target and every commit against the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (flushReq && expQ.size() > 0)
                checkOutput("flush_pc", {96'd0, flushPc}, {96'd0, expQ[0].target});
            if ({excpTaken, irqTaken, mretEna, excpAck, irqAck, mretAck} != 6'd0) begin
                if (expQ.size() == 0) begin
                    checkOutput("stray_commit", {122'd0, excpTaken, irqTaken, mretEna,
                                                 excpAck, irqAck, mretAck}, 128'd0);
                end else begin
                    monEntry = expQ.pop_front();
                    checkOutput("commit_strobe", {125'd0, excpTaken, irqTaken, mretEna}, {125'd0, monEntry.kind});
                    checkOutput("commit_ack", {125'd0, excpAck, irqAck, mretAck}, {125'd0, monEntry.kind});
                    checkOutput("trap_cause", {96'd0, trapCause}, {96'd0, monEntry.cause});
                    checkOutput("trap_epc", {96'd0, trapEpc}, {96'd0, monEntry.epc});
                end
            end
        end
    end

    initial begin
        int seen;
        int strobes;

        // Reset state.
        #1;
        checkAllZero("reset_outputs");
        repeat (3) stepCycle();
        rst = 1'b0;
        stepCycle();

        // Exception, minimum latency.
        mtvec = 32'h100;
        applyStimulus(1'b1, 32'd2, 1'b0, 1'b0, 32'd0, 32'h40);
        pushExp(K_EXCP, 32'd2, 32'h40, 32'h100);
        @(negedge clk);
        checkOutput("excp_n_busy", {127'd0, busy}, 128'd0);
        stepCycle();
        @(negedge clk);
        checkOutput("excp_n1_quiesce", {126'd0, busy, flushReq}, 128'd2);
        stepCycle();
        @(negedge clk);
        checkOutput("excp_n2_flush", {127'd0, flushReq}, 128'd1);
        checkOutput("excp_n2_pc", {96'd0, flushPc}, 128'h100);
        stepCycle();
        @(negedge clk);
        checkOutput("excp_n3_strobe", {126'd0, excpTaken, excpAck}, 128'd3);
        stepCycle();
        excpReq = 1'b0;
        @(negedge clk);
        checkOutput("excp_back_idle", {127'd0, busy}, 128'd0);

        // Vectored interrupt.
        stepCycle();
        mtvec    = 32'h201;
        irqGlbEn = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'd7, 32'h300);
        pushExp(K_IRQ, 32'd7, 32'h300, 32'h21C);
        waitAck(K_IRQ, "irq_vec_ack");
        irqReq = 1'b0;
        repeat (3) stepCycle();

        // Simultaneous exception and interrupt: exception first, irq right after.
        mtvec = 32'h101;
        applyStimulus(1'b1, 32'd4, 1'b0, 1'b1, 32'd3, 32'h50);
        pushExp(K_EXCP, 32'd4, 32'h50, 32'h100);
        pushExp(K_IRQ, 32'd3, 32'h54, 32'h10C);
        stepCycle();
        epcIn = 32'h54;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (excpAck) break;
        end
        checkOutput("dual_excp_ack", {127'd0, excpAck}, 128'd1);
        stepCycle();
        excpReq = 1'b0;
        @(negedge clk);
        checkOutput("dual_idle_gap", {127'd0, busy}, 128'd0);
        stepCycle();
        @(negedge clk);
        checkOutput("dual_irq_accepted", {127'd0, busy}, 128'd1);
        waitAck(K_IRQ, "dual_irq_ack");
        irqReq   = 1'b0;
        irqGlbEn = 1'b0;
        repeat (2) stepCycle();

        // Slow drain and delayed flush acknowledge.
        mtvec     = 32'h400;
        oitfEmpty = 1'b0;
        flushAck  = 1'b0;
        applyStimulus(1'b1, 32'd5, 1'b0, 1'b0, 32'd0, 32'h44);
        pushExp(K_EXCP, 32'd5, 32'h44, 32'h400);
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            @(negedge clk);
            checkOutput("drain_hold", {126'd0, busy, flushReq}, 128'd2);
        end
        stepCycle();
        oitfEmpty = 1'b1;
        @(negedge clk);
        checkOutput("drain_last", {127'd0, flushReq}, 128'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            stepCycle();
            if (seen == 2) flushAck = 1'b1;
            @(negedge clk);
            if (flushReq) seen++;
            else break;
        end
        checkOutput("flush_hold_cycles", 128'(seen), 128'd3);
        checkOutput("slow_commit", {127'd0, excpTaken}, 128'd1);
        stepCycle();
        excpReq = 1'b0;
        stepCycle();

        // Reset while flushing.
        mtvec    = 32'h100;
        flushAck = 1'b0;
        applyStimulus(1'b1, 32'd6, 1'b0, 1'b0, 32'd0, 32'h60);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (flushReq) begin
                seen = 1;
                break;
            end
        end
        checkOutput("rst_reach_flush", 128'(seen), 128'd1);
        #2;
        rst     = 1'b1;
        excpReq = 1'b0;
        #1;
        checkAllZero("rst_mid_flush");
        stepCycle();
        stepCycle();
        rst      = 1'b0;
        flushAck = 1'b1;
        strobes  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if ({excpTaken, irqTaken, mretEna, excpAck, irqAck, mretAck} != 6'd0) strobes++;
            stepCycle();
        end
        checkOutput("rst_no_strobe", 128'(strobes), 128'd0);
        checkOutput("rst_idle", {127'd0, busy}, 128'd0);

        // Debug mode masks irq; mret still commits.
        dbgMode  = 1'b1;
        irqGlbEn = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'd3, 32'h70);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("dbg_irq_masked", {127'd0, busy}, 128'd0);
            stepCycle();
        end
        mepc = 32'h80;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'd3, 32'h90);
        pushExp(K_MRET, 32'd0, 32'h90, 32'h80);
        waitAck(K_MRET, "dbg_mret_ack");
        mretReq = 1'b0;
        mepc    = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("dbg_irq_still_masked", {127'd0, busy}, 128'd0);
            stepCycle();
        end
        irqReq   = 1'b0;
        dbgMode  = 1'b0;
        irqGlbEn = 1'b0;
        repeat (3) stepCycle();

        checkOutput("scoreboard_empty", 128'(expQ.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
